// File: rtl/dfsm_v4_pkg.sv
// Shared types and helpers for the dfsm_v4 dataflow sequencer.
// Optional stall counter is enabled by DFSM_STALL_CNT_EN.
package dfsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LMAC = 2'd2,
    SHFT = 2'd3
  } state_e;

  localparam logic mdCONV = 1'b0;
  localparam logic mdMM   = 1'b1;

  localparam int DLY_LMAC = 2;
  localparam int DLY_RD   = 2;
  localparam int DLY_WGT  = 3;
  localparam int DLY_ACC  = 4;
  localparam int DLY_SHFT = 3;
  localparam int DLY_MM   = 3;

  function automatic int fw(input int mx);
    return $clog2(mx) + 1;
  endfunction

  function automatic int PW(input int mx);
    return fw(mx);
  endfunction

  function automatic int LW(input int mx);
    return fw(mx);
  endfunction

  function automatic int SW(input int mx);
    return fw(mx);
  endfunction

  // zero means one; anything above the maximum saturates
  function automatic int unsigned clampf(
    input int unsigned v,
    input int unsigned mx
  );
    if (v == 0) return 1;
    if (v > mx) return mx;
    return v;
  endfunction

endpackage

// File: rtl/dfsm_v4_if.sv
// Job/control bundle between the MAC-array datapath and dfsm_v4.
// stall_cnt exists only when DFSM_STALL_CNT_EN is defined.
interface dfsm_v4_if #(
  parameter int CW = 29
);
  logic          start;
  logic [CW-1:0] config_bits;
  logic          all_data_rdy;
  logic          in_en;
  logic          start_out;
  logic          in_en_bypass;
  logic          data_preread;
  logic          busy;
  logic          done;
  logic          lmac_en;
  logic          rd_en;
  logic          wgt_en;
  logic          acc_en;
  logic          shft_en;
  logic          flush;
  logic          mm_en;
`ifdef DFSM_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  modport slave (
    input  start, config_bits, all_data_rdy, in_en,
`ifdef DFSM_STALL_CNT_EN
    output stall_cnt,
`endif
    output start_out, in_en_bypass, data_preread, busy, done,
    output lmac_en, rd_en, wgt_en, acc_en, shft_en, flush, mm_en
  );

  modport master (
    output start, config_bits, all_data_rdy, in_en,
`ifdef DFSM_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  start_out, in_en_bypass, data_preread, busy, done,
    input  lmac_en, rd_en, wgt_en, acc_en, shft_en, flush, mm_en
  );
endinterface

// File: rtl/dfsm_v4_dly_line.sv
// Fixed-depth strobe delay line with synchronous active-low clear.
module dfsm_dly_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dfsm_v4.sv
// Dataflow sequencer: periods of LMAC/SHFT with WAIT stalls, delayed strobes.
// Define DFSM_STALL_CNT_EN to add the stall_cnt status counter.
module dfsm_v4
  import dfsm_pkg::*;
#(
  parameter int MAX_nPERIOD = 8,
  parameter int MAX_nLMAC   = 12288,
  parameter int MAX_nSHFT   = 192,
  parameter int EXTRA_DLY   = 0
) (
  input logic       clk,
  input logic       rst,
  dfsm_v4_if.slave  bus
);

  localparam int PWD = PW(MAX_nPERIOD);
  localparam int LWD = LW(MAX_nLMAC);
  localparam int SWD = SW(MAX_nSHFT);
  localparam int CW  = 1 + PWD + LWD + SWD;
  localparam int CNW = fw((MAX_nLMAC > MAX_nSHFT) ? MAX_nLMAC : MAX_nSHFT);
  localparam int FD  = MAX_nSHFT + 2 + EXTRA_DLY;
  localparam int FW  = $clog2(FD);

  state_e         state_q, state_d;
  logic [CNW-1:0] mac_q, mac_d;
  logic [PWD-1:0] per_q, per_d;
  logic [PWD-1:0] nper_q, nper_d;
  logic [LWD-1:0] nlmac_q, nlmac_d;
  logic [SWD-1:0] nshft_q, nshft_d;
  logic           mode_q, mode_d;
  logic           done_q, done_d;
  logic           start_q, inen_q;
  logic [FD-1:0]  fl_q;

  logic [CW-1:0]  cfg;
  logic [PWD-1:0] cfg_np;
  logic [LWD-1:0] cfg_nl;
  logic [SWD-1:0] cfg_ns;
  logic           rdy, accept;
  logic           lm_last, sh_last, per_last;
  logic [FW-1:0]  tap;

  assign cfg    = bus.config_bits;
  assign rdy    = bus.all_data_rdy;
  assign accept = (state_q == IDLE) && bus.start;
  assign cfg_np = PWD'(clampf(32'(cfg[CW-2 -: PWD]), MAX_nPERIOD));
  assign cfg_nl = LWD'(clampf(32'(cfg[LWD+SWD-1 -: LWD]), MAX_nLMAC));
  assign cfg_ns = SWD'(clampf(32'(cfg[SWD-1:0]), MAX_nSHFT));

  assign lm_last  = mac_q == CNW'(nlmac_q - 1'b1);
  assign sh_last  = mac_q == CNW'(nshft_q - 1'b1);
  assign per_last = per_q == nper_q - 1'b1;

  always_comb begin
    state_d = state_q;
    mac_d   = mac_q;
    per_d   = per_q;
    mode_d  = mode_q;
    nper_d  = nper_q;
    nlmac_d = nlmac_q;
    nshft_d = nshft_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = cfg[CW-1];
          nper_d  = cfg_np;
          nlmac_d = cfg_nl;
          nshft_d = cfg_ns;
          mac_d   = '0;
          per_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (rdy) state_d = LMAC;
      end
      LMAC: begin
        if (lm_last) begin
          mac_d   = '0;
          state_d = SHFT;
        end else begin
          mac_d = mac_q + 1'b1;
          if (!rdy) state_d = WAIT;
        end
      end
      SHFT: begin
        if (sh_last) begin
          mac_d = '0;
          per_d = per_q + 1'b1;
          if (per_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = rdy ? LMAC : WAIT;
          end
        end else begin
          mac_d = mac_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mac_q   <= '0;
      per_q   <= '0;
      mode_q  <= mdCONV;
      nper_q  <= '0;
      nlmac_q <= '0;
      nshft_q <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      inen_q  <= 1'b0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      mac_q   <= mac_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      nper_q  <= nper_d;
      nlmac_q <= nlmac_d;
      nshft_q <= nshft_d;
      done_q  <= done_d;
      start_q <= bus.start;
      inen_q  <= bus.in_en;
      fl_q    <= {fl_q[FD-2:0], (state_q == SHFT) && (mac_q == '0)};
    end
  end

  logic is_lmac, is_rw, is_shft, is_mm;
  logic lmac_dly, rd_dly, wgt_dly, acc_dly, shft_dly, mm_dly;

  assign is_lmac = state_q == LMAC;
  assign is_rw   = (state_q == LMAC) || (state_q == WAIT);
  assign is_shft = state_q == SHFT;
  assign is_mm   = is_lmac && (mode_q == mdMM);

  dfsm_dly_line #(.WIDTH(1), .DEPTH(DLY_LMAC + EXTRA_DLY)) u_lmac (
    .clk_i(clk), .clr_ni(rst), .d_i(is_lmac), .q_o(lmac_dly));
  dfsm_dly_line #(.WIDTH(1), .DEPTH(DLY_RD + EXTRA_DLY)) u_rd (
    .clk_i(clk), .clr_ni(rst), .d_i(is_rw), .q_o(rd_dly));
  dfsm_dly_line #(.WIDTH(1), .DEPTH(DLY_WGT + EXTRA_DLY)) u_wgt (
    .clk_i(clk), .clr_ni(rst), .d_i(is_rw), .q_o(wgt_dly));
  dfsm_dly_line #(.WIDTH(1), .DEPTH(DLY_ACC + EXTRA_DLY)) u_acc (
    .clk_i(clk), .clr_ni(rst), .d_i(is_lmac), .q_o(acc_dly));
  dfsm_dly_line #(.WIDTH(1), .DEPTH(DLY_SHFT + EXTRA_DLY)) u_shft (
    .clk_i(clk), .clr_ni(rst), .d_i(is_shft), .q_o(shft_dly));
  dfsm_dly_line #(.WIDTH(1), .DEPTH(DLY_MM + EXTRA_DLY)) u_mm (
    .clk_i(clk), .clr_ni(rst), .d_i(is_mm), .q_o(mm_dly));

  // tap follows the shadowed shift length so flush lands after the last shift-out
  assign tap = FW'(nshft_q) + FW'(EXTRA_DLY + 1);

  assign bus.start_out    = start_q;
  assign bus.in_en_bypass = inen_q;
  assign bus.data_preread = is_lmac;
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = done_q;
  assign bus.lmac_en      = lmac_dly;
  assign bus.rd_en        = rd_dly;
  assign bus.wgt_en       = wgt_dly;
  assign bus.acc_en       = acc_dly;
  assign bus.shft_en      = shft_dly;
  assign bus.mm_en        = mm_dly;
  assign bus.flush        = fl_q[tap];

`ifdef DFSM_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        seen_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      seen_q  <= 1'b0;
    end else if (accept) begin
      stall_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      if (is_lmac) seen_q <= 1'b1;
      if ((state_q == WAIT) && seen_q && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
